lsu_subword: RTL and testbench
==============================

# lsu_subword

Load/store unit between the core's memory stage and the word-only data memory. The data memory has one write enable, no byte enables and a one-cycle read latency. This block accepts byte, halfword and word loads and stores and does all the work the memory cannot. Sub-word stores become a read-modify-write sequence, loads are extracted and sign- or zero-extended, and misaligned or out-of-range accesses are rejected with an error response instead of touching memory.

## Interface
Parameters:
- BASE, 32'h8000_0000, byte address of data-memory word 0
- AW, 10, word-address width of the data memory (depth 2^AW words)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  core request valid
- req_ready  out  1  block can accept a request
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  in  1  zero-extend load result (ignored for stores and word loads)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  one-cycle completion pulse
- resp_err  out  1  qualifies resp_valid: request rejected, no memory access
- resp_rdata  out  32  load result; 0 for stores and errors
- mem_addr  out  32  to data memory, always {word address, 2'b00}
- mem_wdata  out  32  to data memory
- mem_we  out  1  to data memory
- mem_rdata  in  32  from data memory, valid the cycle after the address was presented with mem_we=0

## Operation
- States: IDLE, READ, WAIT, WRITE, RESP. Reset puts the FSM in IDLE.
- IDLE:
  - req_ready=1.
  - On req_valid, latch all req_* fields.
- Error check, done at accept. Any of these sends the FSM to RESP with resp_err=1:
  - size 11
  - half with addr[0]=1
  - word with addr[1:0]≠0
  - (addr−BASE) ≥ 4·2^AW, unsigned 32-bit compare
- After the error check passes:
  - Word store goes to WRITE with the write buffer = req_wdata.
  - Any load or sub-word store goes to READ.
- READ: mem_addr = latched word address, mem_we=0. Next state WAIT.
- WAIT, mem_rdata valid:
  - Load: extract the result into resp_rdata, then go to RESP.
    - Byte: lane addr[1:0].
    - Half: lane addr[1].
    - Word: unchanged.
    - Sign-extend from bit 7 or 15 unless req_unsigned.
  - Sub-word store: merge into the write buffer, then go to WRITE.
    - Byte: replace byte lane addr[1:0] with wdata[7:0].
    - Half: replace half lane addr[1] with wdata[15:0].
    - Other lanes keep mem_rdata.
- WRITE: mem_we=1, mem_addr = word address, mem_wdata = write buffer. Next state RESP.
- RESP: resp_valid=1 for exactly one cycle. Next state IDLE.
- req_ready=0 in every state except IDLE.
- mem_we is decoded only from the state register and is 1 only in WRITE.
- mem_addr holds the latched word address outside IDLE and is 0 in IDLE.
- Memory writes only in WRITE, never for errors or loads.

## Timing
- Cycle C0 is the accept cycle (req_valid & req_ready). resp_valid is high in:
  - Load: C3
  - Sub-word store: C4
  - Word store: C2
  - Error: C1
- Back-to-back: the next request can be accepted in the cycle after RESP. No overlap and no pipelining.
- resp_err and resp_rdata are registered and stable only while resp_valid=1. Both return to 0 in IDLE.
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_addr=0, mem_wdata=0, mem_we=0.
- Reset asserted mid-transaction:
  - The transaction is discarded with no response.
  - mem_we drops asynchronously.
  - A WRITE interrupted by reset has undefined memory effect.
- Inputs other than req_valid are ignored outside the accept cycle. Changes to them after C0 do not affect the transaction.

## Test plan
- Word store 0xDEADBEEF to 0x8000_0010, then word load from the same address: resp_valid at C2 with err=0, then the load returns 0xDEADBEEF at C3. mem_we is high only in the store's C1.
- Byte store 0xA5 to 0x8000_0011 over 0xDEADBEEF: exactly one read then one write of 0xDEADA5EF. resp at C4. A following signed byte load returns 0xFFFF_FFA5; unsigned returns 0x0000_00A5.
- Half store 0x1234 to 0x8000_0012, then signed half load: memory word = 0x1234A5EF and the load returns 0x0000_1234. A half store of 0x8001 followed by a signed load returns 0xFFFF_8001.
- Errors, each with resp_err=1 at C1, resp_rdata=0, mem_we never high and memory unchanged:
  - half access at 0x8000_0013
  - word access at 0x8000_0002
  - size 11
  - address 0x8000_1000 (AW=10)
  - address 0x7FFF_FFFC
- Reset asserted during WAIT of a byte store: mem_we stays 0, no resp_valid, and the memory word is unchanged. After reset release req_ready=1 and a new load completes normally.
- Back-to-back requests with req_valid held high: accepts occur only in IDLE cycles and responses arrive in order with the stated latencies.

Source files
------------

// File: rtl/lsu_subword.sv
// lsu_subword: load/store unit between the core memory stage and a word-only
// data memory (single write enable, one-cycle read latency).
// Sub-word stores become read-modify-write. Loads are lane-extracted and
// sign/zero-extended. Misaligned or out-of-range requests get an error
// response and never touch memory.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   req_valid/ready    core request handshake (ready only in IDLE)
//   req_we             1 = store, 0 = load
//   req_size           00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned       zero-extend sub-word load results
//   req_addr           byte address
//   req_wdata          right-aligned store data
//   resp_valid         one-cycle completion pulse
//   resp_err           request rejected (qualified by resp_valid)
//   resp_rdata         load result, 0 for stores and errors
//   mem_addr           {word index, 2'b00} to data memory, 0 in IDLE
//   mem_wdata/mem_we   write port to data memory
//   mem_rdata          read data, valid one cycle after the address
module lsu_subword #(
   parameter logic [31:0] BASE = 32'h8000_0000,
   parameter int unsigned AW   = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic        resp_err,
   output logic [31:0] resp_rdata,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_we,
   input  logic [31:0] mem_rdata
);

   // Byte span of the data memory; 33 bits so large AW cannot overflow.
   localparam logic [32:0] LIMIT = 33'(4) << AW;

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_WAIT,
      S_WRITE,
      S_RESP
   } state_t;

   state_t state, state_nx;

   logic          we_q;
   logic [1:0]    size_q;
   logic          uns_q;
   logic [1:0]    lane_q;
   logic [AW-1:0] idx_q;
   logic [31:0]   wdata_q;
   logic [31:0]   wbuf_q;
   logic [31:0]   rdata_q;
   logic          err_q;

   logic [31:0]   off;
   logic          bad;
   logic          word_store;
   logic [7:0]    ld_byte;
   logic [15:0]   ld_half;
   logic [31:0]   ld_val;
   logic [31:0]   merged;

   // Request decode at accept: offset into memory and rejection conditions.
   always_comb begin
      off        = req_addr - BASE;
      bad        = 1'b0;
      if (req_size == 2'b11)                              bad = 1'b1;
      if ((req_size == 2'b01) && req_addr[0])             bad = 1'b1;
      if ((req_size == 2'b10) && (req_addr[1:0] != 2'b00)) bad = 1'b1;
      if ({1'b0, off} >= LIMIT)                           bad = 1'b1;
      word_store = req_we && (req_size == 2'b10);
   end

   // Load extraction and store merge, both from the returned memory word.
   always_comb begin
      ld_byte = 8'(mem_rdata >> {lane_q, 3'b000});
      ld_half = 16'(mem_rdata >> {lane_q[1], 4'b0000});
      ld_val  = mem_rdata;
      merged  = mem_rdata;
      case (size_q)
         2'b00: begin
            ld_val = uns_q ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
         end
         2'b01: begin
            ld_val = uns_q ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
            merged[{lane_q[1], 4'b0000} +: 16] = wdata_q[15:0];
         end
         default: ;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   // Next-state and state-decoded outputs.
   always_comb begin
      state_nx   = state;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = 32'h0;
      case (state)
         S_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               if (bad)             state_nx = S_RESP;
               else if (word_store) state_nx = S_WRITE;
               else                 state_nx = S_READ;
            end
         end
         S_READ: begin
            mem_addr = 32'({idx_q, 2'b00});
            state_nx = S_WAIT;
         end
         S_WAIT: begin
            mem_addr = 32'({idx_q, 2'b00});
            state_nx = we_q ? S_WRITE : S_RESP;
         end
         S_WRITE: begin
            mem_addr = 32'({idx_q, 2'b00});
            mem_we   = 1'b1;
            state_nx = S_RESP;
         end
         S_RESP: begin
            mem_addr   = 32'({idx_q, 2'b00});
            resp_valid = 1'b1;
            state_nx   = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // Request latch, write buffer and response registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         we_q    <= 1'b0;
         size_q  <= 2'b00;
         uns_q   <= 1'b0;
         lane_q  <= 2'b00;
         idx_q   <= '0;
         wdata_q <= 32'h0;
         wbuf_q  <= 32'h0;
         rdata_q <= 32'h0;
         err_q   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  we_q    <= req_we;
                  size_q  <= req_size;
                  uns_q   <= req_unsigned;
                  lane_q  <= req_addr[1:0];
                  idx_q   <= off[AW+1:2];
                  wdata_q <= req_wdata;
                  err_q   <= bad;
                  if (!bad && word_store) wbuf_q <= req_wdata;
               end
            end
            S_WAIT: begin
               if (we_q) wbuf_q  <= merged;
               else      rdata_q <= ld_val;
            end
            S_RESP: begin
               err_q   <= 1'b0;
               rdata_q <= 32'h0;
            end
            default: ;
         endcase
      end
   end

   assign resp_err   = err_q;
   assign resp_rdata = rdata_q;
   assign mem_wdata  = wbuf_q;

endmodule

// File: tb/tb_lsu_subword.sv
// tb_lsu_subword: bench for lsu_subword with a word memory model, a
// byte-array reference model, directed vectors, a reset-abort sequence,
// back-to-back requests and randomized traffic.
module tb_lsu_subword;

   localparam logic [31:0] BASE  = 32'h8000_0000;
   localparam int unsigned AW    = 10;
   localparam int unsigned WORDS = 1 << AW;
   localparam int unsigned BYTES = 4 * WORDS;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_err;
   logic [31:0] resp_rdata;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_we;
   logic [31:0] mem_rdata;

   lsu_subword #(.BASE(BASE), .AW(AW)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_size(req_size), .req_unsigned(req_unsigned),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
      .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] init_word(input int i);
      return 32'(i) * 32'h9E37_79B1 + 32'h0123_4567;
   endfunction

   // Word memory with one-cycle read latency.
   logic [31:0] mem_w [WORDS];
   logic        mem_init;
   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < int'(WORDS); i++) mem_w[i] <= init_word(i);
      end else begin
         if (mem_we) mem_w[mem_addr[AW+1:2]] <= mem_wdata;
         mem_rdata <= mem_w[mem_addr[AW+1:2]];
      end
   end

   // Reference memory as a flat byte array.
   byte unsigned ref_b [BYTES];

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Reference model: sequential semantics of one request.
   task automatic model(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic e, output logic [31:0] rd, output int lat,
                        output int nwr, output logic [31:0] ww, output logic [31:0] wa);
      logic [31:0] off;
      int n;
      longint v;
      off = addr - BASE;
      n   = 1 << size;
      e   = (size == 2'b11) || ((addr % n) != 0) || (off >= BYTES);
      rd = 0; lat = 1; nwr = 0; ww = 0; wa = 0;
      if (e) return;
      if (!we) begin
         v = 0;
         for (int j = 0; j < n; j++) v = v + (longint'(ref_b[off + j]) << (8 * j));
         if (!uns && n < 4 && ((v >> (8 * n - 1)) & 1) == 1) v = v - (longint'(1) << (8 * n));
         rd  = 32'(v);
         lat = 3;
      end else begin
         for (int j = 0; j < n; j++) ref_b[off + j] = 8'(wdata >> (8 * j));
         wa = off & ~32'h3;
         for (int j = 0; j < 4; j++) ww = ww | (32'(ref_b[wa + j]) << (8 * j));
         nwr = 1;
         lat = (n == 4) ? 2 : 4;
      end
   endtask

   // One request from IDLE; observes latency, response and memory writes.
   task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output int lat, output logic e, output logic [31:0] rd,
                         output int nwr, output logic [31:0] ww, output logic [31:0] wa);
      int k;
      logic got;
      req_we = we; req_size = size; req_unsigned = uns;
      req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_we = 1'($urandom); req_size = 2'($urandom); req_unsigned = 1'($urandom);
      req_addr = $urandom; req_wdata = $urandom;
      k = 1; got = 1'b0; nwr = 0; ww = 0; wa = 0; e = 1'bx; rd = 'x;
      while (k < 12) begin
         if (mem_we) begin nwr++; ww = mem_wdata; wa = mem_addr; end
         if (resp_valid) begin got = 1'b1; e = resp_err; rd = resp_rdata; break; end
         @(posedge clk); #1;
         k++;
      end
      lat = got ? k : 0;
      @(posedge clk); #1;
      chk("resp_pulse_one_cycle", 32'(resp_valid), 32'd0);
   endtask

   // Runs one request and compares against expectations from the model.
   task automatic run_model_req(input string tag, input logic we, input logic [1:0] size,
                                input logic uns, input logic [31:0] addr, input logic [31:0] wdata);
      logic me, ae; logic [31:0] mrd, mww, mwa, ard, aww, awa;
      int mlat, mnwr, alat, anwr;
      model(we, size, uns, addr, wdata, me, mrd, mlat, mnwr, mww, mwa);
      do_req(we, size, uns, addr, wdata, alat, ae, ard, anwr, aww, awa);
      chk({tag, "_lat"},    32'(alat), 32'(mlat));
      chk({tag, "_err"},    32'(ae),   32'(me));
      chk({tag, "_rdata"},  ard,       mrd);
      chk({tag, "_writes"}, 32'(anwr), 32'(mnwr));
      if (mnwr == 1) begin
         chk({tag, "_wdata"}, aww, mww);
         chk({tag, "_waddr"}, awa, mwa);
      end
   endtask

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        err;
      logic [31:0] rdata;
      int          lat;
   } vec_t;

   localparam int NV = 21;
   vec_t vt [NV];

   localparam int NB = 6;
   vec_t bq [NB];

   typedef struct {
      logic        err;
      logic [31:0] rdata;
      int          lat;
      int          acc;
   } exp_t;

   initial begin
      logic me, ae; logic [31:0] mrd, mww, mwa, ard, aww, awa;
      int mlat, mnwr, alat, anwr;
      int cnt_we, cnt_rv, mism, cyc, nr, ni, prev_resp;
      logic rdy;
      exp_t eq [$];
      exp_t ex;

      // Directed vectors with hand-derived expectations.
      vt[0]  = '{1'b1, 2'd2, 1'b0, 32'h8000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0,          2};
      vt[1]  = '{1'b0, 2'd2, 1'b0, 32'h8000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF,  3};
      vt[2]  = '{1'b1, 2'd0, 1'b0, 32'h8000_0011, 32'h1234_56A5, 1'b0, 32'h0,          4};
      vt[3]  = '{1'b0, 2'd0, 1'b0, 32'h8000_0011, 32'h0,         1'b0, 32'hFFFF_FFA5,  3};
      vt[4]  = '{1'b0, 2'd0, 1'b1, 32'h8000_0011, 32'h0,         1'b0, 32'h0000_00A5,  3};
      vt[5]  = '{1'b0, 2'd2, 1'b0, 32'h8000_0010, 32'h0,         1'b0, 32'hDEAD_A5EF,  3};
      vt[6]  = '{1'b1, 2'd1, 1'b0, 32'h8000_0012, 32'hFFFF_1234, 1'b0, 32'h0,          4};
      vt[7]  = '{1'b0, 2'd2, 1'b0, 32'h8000_0010, 32'h0,         1'b0, 32'h1234_A5EF,  3};
      vt[8]  = '{1'b0, 2'd1, 1'b0, 32'h8000_0012, 32'h0,         1'b0, 32'h0000_1234,  3};
      vt[9]  = '{1'b1, 2'd1, 1'b0, 32'h8000_0012, 32'h0000_8001, 1'b0, 32'h0,          4};
      vt[10] = '{1'b0, 2'd1, 1'b0, 32'h8000_0012, 32'h0,         1'b0, 32'hFFFF_8001,  3};
      vt[11] = '{1'b0, 2'd1, 1'b1, 32'h8000_0012, 32'h0,         1'b0, 32'h0000_8001,  3};
      vt[12] = '{1'b1, 2'd1, 1'b0, 32'h8000_0013, 32'hFFFF_FFFF, 1'b1, 32'h0,          1};
      vt[13] = '{1'b1, 2'd2, 1'b0, 32'h8000_0002, 32'hFFFF_FFFF, 1'b1, 32'h0,          1};
      vt[14] = '{1'b1, 2'd3, 1'b0, 32'h8000_0010, 32'hFFFF_FFFF, 1'b1, 32'h0,          1};
      vt[15] = '{1'b1, 2'd2, 1'b0, 32'h8000_1000, 32'hFFFF_FFFF, 1'b1, 32'h0,          1};
      vt[16] = '{1'b0, 2'd2, 1'b0, 32'h7FFF_FFFC, 32'h0,         1'b1, 32'h0,          1};
      vt[17] = '{1'b0, 2'd2, 1'b0, 32'h8000_0010, 32'h0,         1'b0, 32'h8001_A5EF,  3};
      vt[18] = '{1'b1, 2'd2, 1'b0, 32'h8000_0FFC, 32'h1122_3344, 1'b0, 32'h0,          2};
      vt[19] = '{1'b0, 2'd0, 1'b1, 32'h8000_0FFF, 32'h0,         1'b0, 32'h0000_0011,  3};
      vt[20] = '{1'b0, 2'd1, 1'b0, 32'h8000_0FFE, 32'h0,         1'b0, 32'h0000_1122,  3};

      for (int i = 0; i < int'(WORDS); i++)
         for (int j = 0; j < 4; j++) ref_b[4 * i + j] = 8'(init_word(i) >> (8 * j));

      rst = 1'b1; mem_init = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
      req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_req_ready",  32'(req_ready),  32'd1);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_resp_err",   32'(resp_err),   32'd0);
      chk("rst_resp_rdata", resp_rdata,      32'h0);
      chk("rst_mem_addr",   mem_addr,        32'h0);
      chk("rst_mem_wdata",  mem_wdata,       32'h0);
      chk("rst_mem_we",     32'(mem_we),     32'd0);
      @(negedge clk); rst = 1'b0; mem_init = 1'b0;
      @(posedge clk); #1;

      // Directed table.
      for (int i = 0; i < NV; i++) begin
         model(vt[i].we, vt[i].size, vt[i].uns, vt[i].addr, vt[i].wdata,
               me, mrd, mlat, mnwr, mww, mwa);
         do_req(vt[i].we, vt[i].size, vt[i].uns, vt[i].addr, vt[i].wdata,
                alat, ae, ard, anwr, aww, awa);
         chk($sformatf("vec%0d_lat", i),    32'(alat), 32'(vt[i].lat));
         chk($sformatf("vec%0d_err", i),    32'(ae),   32'(vt[i].err));
         chk($sformatf("vec%0d_rdata", i),  ard,       vt[i].rdata);
         chk($sformatf("vec%0d_writes", i), 32'(anwr), 32'(mnwr));
         if (mnwr == 1) chk($sformatf("vec%0d_wdata", i), aww, mww);
      end
      chk("idle_resp_err",   32'(resp_err), 32'd0);
      chk("idle_resp_rdata", resp_rdata,    32'h0);
      chk("idle_mem_addr",   mem_addr,      32'h0);

      // Reset during WAIT of a byte store: no write, no response.
      req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
      req_addr = 32'h8000_0021; req_wdata = 32'h0000_005A; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      chk("abort_mem_we_async", 32'(mem_we),    32'd0);
      chk("abort_req_ready",    32'(req_ready), 32'd1);
      cnt_we = 0; cnt_rv = 0;
      repeat (2) begin
         @(posedge clk); #1;
         if (mem_we) cnt_we++;
         if (resp_valid) cnt_rv++;
      end
      @(negedge clk); rst = 1'b0;
      repeat (4) begin
         @(posedge clk); #1;
         if (mem_we) cnt_we++;
         if (resp_valid) cnt_rv++;
      end
      chk("abort_writes", 32'(cnt_we), 32'd0);
      chk("abort_resps",  32'(cnt_rv), 32'd0);
      chk("abort_word",   mem_w[8],
          {8'(ref_b[35]), 8'(ref_b[34]), 8'(ref_b[33]), 8'(ref_b[32])});
      chk("abort_ready_after", 32'(req_ready), 32'd1);
      run_model_req("after_abort_load", 1'b0, 2'd0, 1'b1, 32'h8000_0021, 32'h0);

      // Back-to-back with req_valid held high.
      bq[0] = '{1'b1, 2'd2, 1'b0, 32'h8000_0040, 32'hCAFE_F00D, 1'b0, 32'h0, 0};
      bq[1] = '{1'b0, 2'd0, 1'b0, 32'h8000_0043, 32'h0,         1'b0, 32'h0, 0};
      bq[2] = '{1'b1, 2'd1, 1'b0, 32'h8000_0041, 32'h0,         1'b0, 32'h0, 0};
      bq[3] = '{1'b1, 2'd1, 1'b0, 32'h8000_0040, 32'h0000_BEEF, 1'b0, 32'h0, 0};
      bq[4] = '{1'b0, 2'd2, 1'b0, 32'h8000_0040, 32'h0,         1'b0, 32'h0, 0};
      bq[5] = '{1'b1, 2'd0, 1'b0, 32'h8000_0042, 32'h0000_0077, 1'b0, 32'h0, 0};
      cyc = 0; nr = 0; ni = 0; prev_resp = -10;
      req_we = bq[0].we; req_size = bq[0].size; req_unsigned = bq[0].uns;
      req_addr = bq[0].addr; req_wdata = bq[0].wdata; req_valid = 1'b1;
      for (int t = 0; t < 80 && nr < NB; t++) begin
         rdy = req_ready;
         @(posedge clk); #1;
         cyc++;
         if (rdy && req_valid) begin
            model(bq[ni].we, bq[ni].size, bq[ni].uns, bq[ni].addr, bq[ni].wdata,
                  me, mrd, mlat, mnwr, mww, mwa);
            eq.push_back('{me, mrd, mlat, cyc - 1});
            if (ni > 0) chk($sformatf("b2b%0d_accept_gap", ni), 32'(cyc - 1), 32'(prev_resp + 1));
            ni++;
            if (ni < NB) begin
               req_we = bq[ni].we; req_size = bq[ni].size; req_unsigned = bq[ni].uns;
               req_addr = bq[ni].addr; req_wdata = bq[ni].wdata;
            end else req_valid = 1'b0;
         end
         if (resp_valid) begin
            prev_resp = cyc;
            if (eq.size() == 0) chk("b2b_unexpected_resp", 32'd1, 32'd0);
            else begin
               ex = eq.pop_front();
               chk($sformatf("b2b%0d_lat", nr),   32'(cyc - ex.acc), 32'(ex.lat));
               chk($sformatf("b2b%0d_err", nr),   32'(resp_err),     32'(ex.err));
               chk($sformatf("b2b%0d_rdata", nr), resp_rdata,        ex.rdata);
            end
            nr++;
         end
      end
      req_valid = 1'b0;
      chk("b2b_resp_count", 32'(nr), 32'(NB));
      @(posedge clk); #1;

      // Randomized traffic against the reference model.
      for (int i = 0; i < 300; i++) begin
         logic [1:0] s; logic [31:0] a; int r;
         s = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         r = $urandom_range(0, 9);
         if (r == 0)      a = $urandom;
         else if (r == 1) a = BASE + BYTES + 32'($urandom_range(0, 15));
         else if (r == 2) a = BASE - 32'($urandom_range(1, 16));
         else             a = BASE + 32'($urandom_range(0, BYTES - 1));
         if (r >= 4 && s != 2'd3) a = a & ~((32'd1 << s) - 32'd1);
         run_model_req($sformatf("rnd%0d", i), 1'($urandom), s, 1'($urandom), a, $urandom);
      end

      // Whole-memory comparison against the reference byte array.
      mism = 0;
      for (int i = 0; i < int'(WORDS); i++)
         if (mem_w[i] !== {8'(ref_b[4*i+3]), 8'(ref_b[4*i+2]), 8'(ref_b[4*i+1]), 8'(ref_b[4*i])})
            mism++;
      chk("final_memory_words_differing", 32'(mism), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
